cgra_mult_arbiter: RTL and testbench
====================================

// Module: cgra_mult_arbiter
// PURPOSE
//   Shares one 2-stage pipelined signed 32x32 multiplier between N_REQ requesters.
//   Requesters are the reconfigurable-cell ALUs that stall on SMUL/FXPMUL.
//   Arbitration is round-robin, with one grant per cycle. Each grant returns one
//   result, with a one-cycle valid_o pulse to the granted requester.
//   Sits between the RC array and a single multiplier, replacing per-ALU multipliers.
// PARAMETERS
//   N_REQ     4   number of requesters (>=2)
//   DP_WIDTH  32  datapath width
//   NBIT_DEC  15  fractional bits of the fixed-point format (Q16.15)
// PORTS
//   clk_i    in   1                 clock
//   rst_ni   in   1                 asynchronous active-low reset
//   clear_i  in   1                 synchronous flush (kernel restart)
//   req_i    in   N_REQ             level request; one op per grant
//   fxp_i    in   N_REQ             1: fixed-point multiply, 0: integer multiply
//   op_a_i   in   N_REQ x DP_WIDTH  operand A per requester, signed
//   op_b_i   in   N_REQ x DP_WIDTH  operand B per requester, signed
//   gnt_o    out  N_REQ             one-hot grant (combinational, same cycle)
//   valid_o  out  N_REQ             one-hot result-valid pulse
//   res_o    out  N_REQ x DP_WIDTH  result; nonzero only in the lane with valid_o=1
//   busy_o   out  1                 any pipeline stage valid
// BEHAVIOUR
// - Reset (rst_ni=0, async): pipeline valids, pending[], res regs cleared; rr_ptr=0.
//   All outputs 0. An in-flight op is discarded; it produces no valid_o after reset.
// - Eligibility: elig[i] = req_i[i] & ~pending[i].
//   pending[i] is set on gnt_o[i]. It is cleared in the cycle valid_o[i]=1, so
//   gnt_o[i] is impossible in the valid_o[i] cycle.
// - Arbitration: gnt_o picks the first eligible index scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//   After a grant to k, rr_ptr <= (k+1) mod N_REQ; with no grant rr_ptr holds.
//   No grant when clear_i=1.
// - Pipeline (grant in cycle T):
//   - S1: end of T captures op_a/op_b/fxp/id of the granted lane.
//   - S2: end of T+1 captures the 64-bit signed product, fxp and id.
//   - Output: during T+2, valid_o[id]=1 and res_o[id]=sel(product), driven from the S2
//     registers. Fixed latency 2 cycles grant->valid.
//   - Pipeline accepts one op per cycle, never stalls. Max throughput 1 result/cycle.
//   - A single requester gets at most one op per 3 cycles (T, T+3, ...).
// - Operand hold: requester keeps op_a/op_b/fxp stable from req rise until gnt_o.
//   Values sampled at the grant edge are used. req held high past valid_o issues a new op.
// - Result select (P = 64-bit signed product):
//   - fxp=0: P[DP_WIDTH-1:0], truncated with no saturation.
//   - fxp=1: P[DP_WIDTH+NBIT_DEC-1:NBIT_DEC], truncated toward -inf with no rounding.
// - clear_i=1: clears S1/S2 valids and pending[], sets rr_ptr=0.
//   No valid_o in the next cycle for discarded ops. valid_o in the clear cycle itself
//   is still delivered.
// - busy_o = S1.valid | S2.valid. Held-low req_i has no effect on an in-flight op
//   (no cancel).
// - Width rule: res_o lanes with valid_o=0 are 0.
// TESTING
// - Single req 0: op_a=7, op_b=-3, fxp=0, req at T.
//   Expect gnt_o=0001 at T; valid_o=0001 at T+2 with res_o[0]=0xFFFFFFEB; all else 0.
// - FXP: op_a=0x00008000 (1.0), op_b=0x00010000 (2.0), fxp=1.
//   Expect res=0x00010000. Also 0xFFFF8000*0x00008000 -> 0xFFFF8000 (-1.0*1.0).
// - All 4 req high from T: grants 0,1,2,3 at T..T+3.
//   Then 0 again at T+4 (pending cleared at T+2). valid_o order 0,1,2,3 at T+2..T+5.
// - Fairness: rr_ptr=2, req=1011 -> grant 3; next cycle req=0001 -> grant 0.
//   With req 0 high continuously alone, grants 3 cycles apart.
// - Reset mid-op: grant at T, rst_ni low during T+1.
//   Expect all outputs 0, no valid_o after release; next grant from index 0.
// - clear_i at T+1 after grant at T: no valid_o at T+2, busy_o=0 at T+2.
//   Held req regranted at T+2.

Source files
------------

// File: rtl/cgra_mult_arbiter.sv
// cgra_mult_arbiter: round-robin sharing of one 2-stage signed multiplier among N_REQ requesters
module cgra_mult_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DP_WIDTH = 32,
  parameter int NBIT_DEC = 15
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic [N_REQ-1:0]                   req_i,
  input  logic [N_REQ-1:0]                   fxp_i,
  input  logic [N_REQ-1:0][DP_WIDTH-1:0]     op_a_i,
  input  logic [N_REQ-1:0][DP_WIDTH-1:0]     op_b_i,
  output logic [N_REQ-1:0]                   gnt_o,
  output logic [N_REQ-1:0]                   valid_o,
  output logic [N_REQ-1:0][DP_WIDTH-1:0]     res_o,
  output logic                               busy_o
);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0]      r_pend, w_elig;
  logic [IW-1:0]         r_ptr, w_id, w_k, r_s1_id, r_s2_id;
  logic                  w_hit, r_s1_v, r_s1_f, r_s2_v;
  logic [DP_WIDTH-1:0]   r_s1_a, r_s1_b, r_s2_res;
  logic [2*DP_WIDTH-1:0] w_p;
  assign w_elig = req_i & ~r_pend;
  // descending scan so the last hit written is the one closest to r_ptr
  always_comb begin
    w_hit = 1'b0;
    w_id  = '0;
    w_k   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      w_k = IW'((int'(r_ptr) + j) % N_REQ);
      if (w_elig[w_k]) begin
        w_hit = 1'b1;
        w_id  = w_k;
      end
    end
    if (clear_i || !rst_ni) w_hit = 1'b0;
  end
  assign gnt_o   = w_hit ? N_REQ'(1) << w_id : '0;
  assign valid_o = r_s2_v ? N_REQ'(1) << r_s2_id : '0;
  assign busy_o  = r_s1_v | r_s2_v;
  assign w_p = {{DP_WIDTH{r_s1_a[DP_WIDTH-1]}}, r_s1_a} * {{DP_WIDTH{r_s1_b[DP_WIDTH-1]}}, r_s1_b};
  always_comb begin
    res_o = '0;
    for (int i = 0; i < N_REQ; i++) res_o[i] = valid_o[i] ? r_s2_res : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend   <= '0;
      r_ptr    <= '0;
      r_s1_v   <= 1'b0;
      r_s1_f   <= 1'b0;
      r_s1_id  <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s2_v   <= 1'b0;
      r_s2_id  <= '0;
      r_s2_res <= '0;
    end else if (clear_i) begin
      r_pend <= '0;
      r_ptr  <= '0;
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      r_pend   <= (r_pend & ~valid_o) | gnt_o;
      r_ptr    <= w_hit ? IW'((int'(w_id) + 1) % N_REQ) : r_ptr;
      r_s1_v   <= w_hit;
      r_s1_f   <= fxp_i[w_id];
      r_s1_id  <= w_id;
      r_s1_a   <= op_a_i[w_id];
      r_s1_b   <= op_b_i[w_id];
      r_s2_v   <= r_s1_v;
      r_s2_id  <= r_s1_id;
      r_s2_res <= r_s1_f ? w_p[DP_WIDTH+NBIT_DEC-1:NBIT_DEC] : w_p[DP_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_cgra_mult_arbiter.sv
// tb_cgra_mult_arbiter: scoreboard bench with a cycle-level reference model of the shared multiplier
module tb_cgra_mult_arbiter;
  localparam int N  = 4;
  localparam int DP = 32;
  localparam int NB = 15;
  localparam int W  = N * DP;
  typedef struct {int due; int lane; logic [DP-1:0] res;} exp_t;
  logic                 clk = 1'b0, rst_ni = 1'b0, clear_i = 1'b0;
  logic [N-1:0]         req_i = '0, fxp_i = '0, gnt_o, valid_o;
  logic [N-1:0][DP-1:0] op_a_i = '0, op_b_i = '0, res_o;
  logic                 busy_o;
  logic [N-1:0]         t_req = '0, t_fxp = '0;
  logic [DP-1:0]        t_a [N], t_b [N];
  int                   m_free [N];
  int                   m_ptr = 0, cyc = 0, total = 0, bad = 0, g;
  bit                   mon_en = 1'b0;
  exp_t                 sb [$];
  cgra_mult_arbiter #(.N_REQ(N), .DP_WIDTH(DP), .NBIT_DEC(NB)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .req_i(req_i), .fxp_i(fxp_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .gnt_o(gnt_o), .valid_o(valid_o), .res_o(res_o),
    .busy_o(busy_o));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", n, cyc, act, exp);
    end
  endtask
  function automatic logic [DP-1:0] refm(input logic [DP-1:0] a, input logic [DP-1:0] b, input logic f);
    longint sa = longint'($signed(a));
    longint sb2 = longint'($signed(b));
    longint p = sa * sb2;
    return f ? DP'(p >>> NB) : DP'(p);
  endfunction
  function automatic logic [DP-1:0] rnd();
    int s = int'($urandom_range(0, 3));
    return s == 0 ? DP'(int'($urandom_range(0, 40)) - 20) :
           s == 1 ? DP'($urandom) :
           s == 2 ? ($urandom_range(0, 1) != 0 ? 32'h8000_0000 : 32'h7fff_ffff) :
                    DP'((int'($urandom_range(0, 8)) - 4) <<< NB);
  endfunction
  task automatic set(input int i, input logic r, input logic f, input logic [DP-1:0] a, input logic [DP-1:0] b);
    t_req[i] = r; t_fxp[i] = f; t_a[i] = a; t_b[i] = b;
  endtask
  task automatic cycle(input bit rst, input bit clr, output int k);
    logic [N-1:0] eg;
    bit busy_e;
    int idx;
    @(negedge clk);
    cyc++;
    rst_ni = !rst; clear_i = clr; req_i = t_req; fxp_i = t_fxp;
    for (int i = 0; i < N; i++) begin op_a_i[i] = t_a[i]; op_b_i[i] = t_b[i]; end
    #1;
    if (rst) begin
      sb.delete();
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_free[i] = 0;
      chk("rst_valid", valid_o, '0);
      chk("rst_res", res_o, '0);
    end
    busy_e = 1'b0;
    foreach (sb[i]) if (sb[i].due == cyc || sb[i].due == cyc + 1) busy_e = 1'b1;
    k = -1;
    if (!rst && !clr)
      for (int j = 0; j < N; j++) begin
        idx = (m_ptr + j) % N;
        if (k < 0 && t_req[idx] && cyc >= m_free[idx]) k = idx;
      end
    eg = k < 0 ? '0 : N'(1) << k;
    chk("gnt", gnt_o, eg);
    chk("busy", busy_o, busy_e);
    if (clr) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due > cyc) sb.delete(i);
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_free[i] = 0;
    end else if (k >= 0) begin
      m_ptr = (k + 1) % N;
      m_free[k] = cyc + 3;
      sb.push_back('{cyc + 2, k, refm(t_a[k], t_b[k], t_fxp[k])});
    end
  endtask
  task automatic idle(input int n);
    t_req = '0;
    repeat (n) cycle(0, 0, g);
  endtask
  initial begin
    logic [N-1:0] ev;
    logic [N-1:0][DP-1:0] er;
    wait (mon_en);
    forever begin
      @(negedge clk);
      #2;
      ev = '0; er = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        ev[sb[0].lane] = 1'b1;
        er[sb[0].lane] = sb[0].res;
        void'(sb.pop_front());
      end
      chk("valid", valid_o, ev);
      chk("res", res_o, er);
    end
  end
  initial begin
    for (int i = 0; i < N; i++) begin t_a[i] = '0; t_b[i] = '0; m_free[i] = 0; end
    t_req = '1;
    cycle(1, 0, g);
    mon_en = 1'b1;
    idle(2);
    set(0, 1, 0, 32'd7, 32'hFFFF_FFFD);
    cycle(0, 0, g);
    idle(3);
    set(1, 1, 1, 32'h0000_8000, 32'h0001_0000);
    cycle(0, 0, g);
    t_req[1] = 1'b0;
    set(2, 1, 1, 32'hFFFF_8000, 32'h0000_8000);
    cycle(0, 0, g);
    idle(3);
    for (int i = 0; i < N; i++) set(i, 1, 1'($urandom_range(0, 1)), rnd(), rnd());
    repeat (8) cycle(0, 0, g);
    idle(4);
    t_req = 4'b0010;
    cycle(0, 0, g);
    t_req = 4'b1011;
    cycle(0, 0, g);
    t_req = 4'b0001;
    cycle(0, 0, g);
    idle(4);
    t_req = 4'b0001;
    repeat (9) cycle(0, 0, g);
    idle(4);
    t_req = 4'b0100;
    cycle(0, 0, g);
    t_req = '0;
    cycle(1, 0, g);
    t_req = 4'b0101;
    cycle(0, 0, g);
    idle(4);
    t_req = 4'b0001;
    cycle(0, 0, g);
    cycle(0, 1, g);
    cycle(0, 0, g);
    cycle(0, 0, g);
    idle(4);
    repeat (600) begin
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0, g);
      for (int i = 0; i < N; i++)
        if (i == g || !t_req[i]) set(i, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rnd(), rnd());
    end
    idle(5);
    #5;
    chk("drain", W'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
